// File: rtl/bwc_pkg.sv
// Shared definitions for the bit word collector and its helpers.
// Holds the default geometry and the fill-level width helper.
package bwc_pkg;

   localparam int DEF_WIDTH      = 8;
   localparam int DEF_SAMPLE_DIV = 4;
   localparam int DIV_W          = 8;

   function automatic int fill_w(input int width);
      return $clog2(width + 1);
   endfunction

endpackage

// File: rtl/bit_sync2.sv
// Two-flop synchroniser for a single asynchronous bit.
// Both flops clear on the synchronous active-high reset.
module bit_sync2 (
   input  logic clk,
   input  logic rst,
   input  logic d,
   output logic q
);

   logic s_p0;
   logic s_p1;

   always_ff @(posedge clk) begin
      if (rst) begin
         s_p0 <= 1'b0;
         s_p1 <= 1'b0;
      end else begin
         s_p0 <= d;
         s_p1 <= s_p0;
      end
   end

   assign q = s_p1;

endmodule

// File: rtl/bit_word_collector.sv
// Samples the synchronised latch-network bit every SAMPLE_DIV clocks and packs it MSB-first
// into WIDTH-bit words on a valid/ready port. Define VON_NEUMANN_EN to debias sample pairs.
module bit_word_collector
   import bwc_pkg::*;
#(
   parameter int WIDTH      = DEF_WIDTH,
   parameter int SAMPLE_DIV = DEF_SAMPLE_DIV
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     enabled,
   input  logic                     b_in,
   output logic [WIDTH-1:0]         word_out,
   output logic                     word_valid,
   input  logic                     word_ready,
   output logic                     overflow,
   output logic [fill_w(WIDTH)-1:0] fill_level
);

   localparam int               FW        = fill_w(WIDTH);
   localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(SAMPLE_DIV - 1);
   localparam logic [FW-1:0]    FILL_LAST = FW'(WIDTH - 1);

   logic             b_s;
   logic [DIV_W-1:0] div_cnt;
   logic             tick;
   logic             acc;
   logic             acc_bit;
   logic [WIDTH-1:0] shreg;
   logic [WIDTH-1:0] next_word;
   logic             complete;

   bit_sync2 u_sync (
      .clk (clk),
      .rst (rst),
      .d   (b_in),
      .q   (b_s)
   );

   // sample-rate divider
   always_ff @(posedge clk) begin
      if (rst || !enabled)
         div_cnt <= '0;
      else if (div_cnt == DIV_LAST)
         div_cnt <= '0;
      else
         div_cnt <= div_cnt + 1'b1;
   end

   assign tick = enabled && (div_cnt == DIV_LAST);

`ifdef VON_NEUMANN_EN
   logic phase;
   logic first;

   // pair ticks: 10 yields 1, 01 yields 0, equal pairs are discarded
   always_ff @(posedge clk) begin
      if (rst) begin
         phase <= 1'b0;
         first <= 1'b0;
      end else if (!enabled) begin
         phase <= 1'b0;
      end else if (tick) begin
         phase <= ~phase;
         if (!phase)
            first <= b_s;
      end
   end

   assign acc     = tick && phase && (first != b_s);
   assign acc_bit = first;
`else
   assign acc     = tick;
   assign acc_bit = b_s;
`endif

   assign next_word = {shreg[WIDTH-2:0], acc_bit};
   assign complete  = acc && (fill_level == FILL_LAST);

   // partial-word assembly
   always_ff @(posedge clk) begin
      if (rst) begin
         shreg      <= '0;
         fill_level <= '0;
      end else if (!enabled) begin
         fill_level <= '0;
      end else if (acc) begin
         shreg      <= next_word;
         fill_level <= complete ? '0 : fill_level + FW'(1);
      end
   end

   // output holding register; a completion with a pending unconsumed word is dropped
   always_ff @(posedge clk) begin
      if (rst) begin
         word_out   <= '0;
         word_valid <= 1'b0;
         overflow   <= 1'b0;
      end else if (complete) begin
         if (!word_valid || word_ready) begin
            word_out   <= next_word;
            word_valid <= 1'b1;
         end else begin
            overflow   <= 1'b1;
         end
      end else if (word_valid && word_ready) begin
         word_valid <= 1'b0;
      end
   end

endmodule

// File: tb/tb_bit_word_collector.sv
// Scoreboard bench for bit_word_collector (WIDTH=8, SAMPLE_DIV=4).
// Expected words are queued as bits are driven and checked on each handshake.
module tb_bit_word_collector;
   import bwc_pkg::*;

   localparam int WIDTH      = 8;
   localparam int SAMPLE_DIV = 4;
   localparam int FW         = fill_w(WIDTH);

   logic             clk = 1'b0;
   logic             rst;
   logic             enabled;
   logic             b_in;
   logic             word_ready;
   logic [WIDTH-1:0] word_out;
   logic             word_valid;
   logic             overflow;
   logic [FW-1:0]    fill_level;

   int               errors = 0;
   int               checks = 0;
   logic [WIDTH-1:0] sb[$];
   logic             mon_en = 1'b0;
   int               vcount = 0;
   logic [WIDTH-1:0] m_acc;
   int               m_cnt;
`ifdef VON_NEUMANN_EN
   logic             m_phase;
   logic             m_first;
`endif

   bit_word_collector #(
      .WIDTH      (WIDTH),
      .SAMPLE_DIV (SAMPLE_DIV)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .enabled    (enabled),
      .b_in       (b_in),
      .word_out   (word_out),
      .word_valid (word_valid),
      .word_ready (word_ready),
      .overflow   (overflow),
      .fill_level (fill_level)
   );

   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic model_clear();
      m_acc = '0;
      m_cnt = 0;
`ifdef VON_NEUMANN_EN
      m_phase = 1'b0;
      m_first = 1'b0;
`endif
   endtask

   task automatic model_accept(input logic b);
      m_acc = {m_acc[WIDTH-2:0], b};
      m_cnt++;
      if (m_cnt == WIDTH) begin
         sb.push_back(m_acc);
         m_cnt = 0;
      end
   endtask

   task automatic model_tick(input logic b);
`ifdef VON_NEUMANN_EN
      if (!m_phase) begin
         m_first = b;
         m_phase = 1'b1;
      end else begin
         m_phase = 1'b0;
         if (m_first != b)
            model_accept(m_first);
      end
`else
      model_accept(b);
`endif
   endtask

   // hold b_in for one sample period; returns just after the tick edge
   task automatic tick_in(input logic b);
      b_in = b;
      model_tick(b);
      repeat (SAMPLE_DIV) step();
   endtask

   always @(negedge clk) begin
      if (mon_en) begin
         if (word_valid)
            vcount++;
         if (word_valid && word_ready) begin
            if (sb.size() == 0)
               check_eq("sb_unexpected", sb.size(), 1);
            else
               check_eq("word", word_out, sb.pop_front());
         end
      end
   end

   initial begin
      logic [WIDTH-1:0] w;
      rst = 1'b1; enabled = 1'b0; b_in = 1'b0; word_ready = 1'b0;
      model_clear();
      repeat (3) step();
      check_eq("rst_word", word_out, 0);
      check_eq("rst_valid", word_valid, 0);
      check_eq("rst_ovf", overflow, 0);
      check_eq("rst_fill", fill_level, 0);
      rst = 1'b0;

`ifndef VON_NEUMANN_EN
      // constant ones, no consumer: first word at edge 31, overflow at edge 63
      b_in = 1'b1; enabled = 1'b1;
      repeat (31) step();
      check_eq("t1_valid_e30", word_valid, 0);
      check_eq("t1_fill_e30", fill_level, 7);
      step();
      check_eq("t1_valid_e31", word_valid, 1);
      check_eq("t1_word_e31", word_out, 8'hFF);
      check_eq("t1_fill_e31", fill_level, 0);
      repeat (31) step();
      check_eq("t1_ovf_e62", overflow, 0);
      step();
      check_eq("t1_ovf_e63", overflow, 1);
      check_eq("t1_word_e63", word_out, 8'hFF);
      check_eq("t1_valid_e63", word_valid, 1);
      repeat (4) step();
      check_eq("t8_fill_pre", fill_level, 1);

      // reset beats enabled and word_ready
      rst = 1'b1; word_ready = 1'b1;
      step();
      check_eq("t8_word", word_out, 0);
      check_eq("t8_valid", word_valid, 0);
      check_eq("t8_ovf", overflow, 0);
      check_eq("t8_fill", fill_level, 0);
      rst = 1'b0; enabled = 1'b0; word_ready = 1'b0;
      step();

      // alternating bits with an always-ready consumer
      model_clear(); mon_en = 1'b1; vcount = 0; word_ready = 1'b1; enabled = 1'b1;
      for (int i = 0; i < 16; i++) tick_in(i % 2 == 0);
      enabled = 1'b0;
      step();
      check_eq("t2_vcycles", vcount, 2);
      check_eq("t2_sb_left", sb.size(), 0);
      check_eq("t2_ovf", overflow, 0);

      // enable drop discards the partial word
      model_clear(); enabled = 1'b1;
      for (int i = 0; i < 5; i++) tick_in(1'b1);
      check_eq("t6_fill5", fill_level, 5);
      enabled = 1'b0; model_clear();
      step();
      check_eq("t6_fill_drop", fill_level, 0);
      enabled = 1'b1;
      for (int i = 0; i < 7; i++) tick_in(1'b1);
      check_eq("t6_fill7", fill_level, 7);
      check_eq("t6_valid7", word_valid, 0);
      tick_in(1'b1);
      check_eq("t6_valid8", word_valid, 1);
      enabled = 1'b0;
      step();

      // completion coinciding with a consume keeps word_valid high
      model_clear(); word_ready = 1'b0; enabled = 1'b1;
      w = 8'h3C;
      for (int i = WIDTH - 1; i >= 0; i--) tick_in(w[i]);
      check_eq("t7_valid1", word_valid, 1);
      check_eq("t7_word1", word_out, 8'h3C);
      w = 8'hC5;
      for (int i = WIDTH - 1; i >= 1; i--) tick_in(w[i]);
      b_in = w[0];
      model_tick(w[0]);
      repeat (SAMPLE_DIV - 1) step();
      word_ready = 1'b1;
      step();
      word_ready = 1'b0;
      check_eq("t7_valid2", word_valid, 1);
      check_eq("t7_word2", word_out, 8'hC5);
      check_eq("t7_ovf", overflow, 0);
      enabled = 1'b0; word_ready = 1'b1;
      step();
      word_ready = 1'b0;
      step();
      check_eq("t7_valid_end", word_valid, 0);
`else
      mon_en = 1'b1; word_ready = 1'b1;
      model_clear(); enabled = 1'b1;
      for (int i = 0; i < 8; i++) begin tick_in(1'b1); tick_in(1'b0); end
      check_eq("vn10_valid", word_valid, 1);
      enabled = 1'b0;
      step();
      model_clear(); enabled = 1'b1;
      for (int i = 0; i < 8; i++) begin tick_in(1'b0); tick_in(1'b1); end
      check_eq("vn01_valid", word_valid, 1);
      enabled = 1'b0;
      step();
      model_clear(); enabled = 1'b1; vcount = 0;
      for (int i = 0; i < 64; i++) tick_in(i % 4 < 2);
      check_eq("vneq_vcycles", vcount, 0);
      check_eq("vneq_fill", fill_level, 0);
      enabled = 1'b0;
      step();
`endif

      check_eq("sb_drained", sb.size(), 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
